// File: rtl/uart_pkg.sv
// Shared UART definitions: transmit FSM states, oversample and stop-tick
// constants, and the clog2 helper that the baud generator also uses.
// With UART_PARITY_EN defined, the transmit FSM includes a PARITY state.
package uart_pkg;

  localparam int unsigned OVS_DEFAULT = 16;

  localparam int unsigned STOP_1   = 16;
  localparam int unsigned STOP_1P5 = 24;
  localparam int unsigned STOP_2   = 32;

`ifdef UART_PARITY_EN
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} tx_state_t;
`else
  typedef enum logic [1:0] {IDLE, START, DATA, STOP} tx_state_t;
`endif

  // Ceiling log2. Returns at least 1 so the result can size a vector.
  function automatic int unsigned clog2(input int unsigned value);
    int unsigned result;
    result = 0;
    for (int unsigned r = 1; r < value; r = r << 1) result++;
    return (result == 0) ? 1 : result;
  endfunction

endpackage

// File: rtl/uart_tx_ctrl_if.sv
// Host byte handshake for the UART transmitter: the data byte, valid from the
// host, and ready from the transmitter.
interface uart_tx_ctrl_if #(
  parameter int unsigned DBIT = 8
);
  logic [DBIT-1:0] tx_data;
  logic            tx_valid;
  logic            tx_ready;

  modport master (output tx_data, output tx_valid, input tx_ready);
  modport slave  (input tx_data, input tx_valid, output tx_ready);
endinterface

// File: rtl/uart_bit_timer.sv
// Oversample tick counter. Counts tick pulses from 0 up to terminal. done is
// high on the tick that completes the count, after which the counter returns
// to 0. clear takes priority over tick. Shared by the transmitter and receiver.
module uart_bit_timer #(
  parameter int unsigned W = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clear,
  input  logic         tick,
  input  logic [W-1:0] terminal,
  output logic         done
);
  logic [W-1:0] cnt;

  assign done = tick && !clear && (cnt == terminal);

  // Counter register: restart on clear or terminal count, otherwise step per tick.
  always_ff @(posedge clk) begin
    if (rst || clear) cnt <= '0;
    else if (tick)    cnt <= done ? '0 : cnt + 1'b1;
  end
endmodule

// File: rtl/uart_tx_ctrl.sv
// UART transmit frame sequencer: start bit, DBIT data bits LSB first, optional
// parity bit, then the stop period, all timed by the 16x oversample tick.
// Define UART_PARITY_EN to add the parity bit (sense set by PAR_ODD).
module uart_tx_ctrl
  import uart_pkg::*;
#(
  parameter int unsigned DBIT    = 8,
  parameter int unsigned OVS     = OVS_DEFAULT,
  parameter int unsigned SB_TICK = STOP_1,
  parameter int unsigned PAR_ODD = 0
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           s_tick,
  uart_tx_ctrl_if.slave  host,
  output logic           tx,
  output logic           tx_busy,
  output logic           tx_done_tick
);
  localparam int unsigned TW = clog2((OVS > SB_TICK) ? OVS : SB_TICK);
  localparam int unsigned BW = clog2(DBIT);

  localparam logic [TW-1:0] BIT_TERM  = TW'(OVS - 1);
  localparam logic [TW-1:0] STOP_TERM = TW'(SB_TICK - 1);
  localparam logic [BW-1:0] LAST_BIT  = BW'(DBIT - 1);

  tx_state_t       state, state_next;
  logic [DBIT-1:0] shreg, shreg_next;
  logic [BW-1:0]   bit_cnt, bit_cnt_next;
  logic            tx_next;
  logic            timer_clear;
  logic [TW-1:0]   terminal;
  logic            tick_done;
`ifdef UART_PARITY_EN
  logic            par_bit, par_next;
`endif

  assign host.tx_ready = (state == IDLE);
  assign tx_busy       = (state != IDLE);

  // The timer is held clear in IDLE, so a tick in the accept cycle is ignored.
  assign timer_clear = (state == IDLE);

  uart_bit_timer #(.W(TW)) u_timer (
    .clk      (clk),
    .rst      (rst),
    .clear    (timer_clear),
    .tick     (s_tick),
    .terminal (terminal),
    .done     (tick_done)
  );

  // State, shift register and line register; tx follows the next state so it is glitch-free.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      shreg   <= '0;
      bit_cnt <= '0;
      tx      <= 1'b1;
`ifdef UART_PARITY_EN
      par_bit <= 1'b0;
`endif
    end else begin
      state   <= state_next;
      shreg   <= shreg_next;
      bit_cnt <= bit_cnt_next;
      tx      <= tx_next;
`ifdef UART_PARITY_EN
      par_bit <= par_next;
`endif
    end
  end

  // Next-state, datapath updates, done pulse and the next line level.
  always_comb begin
    state_next   = state;
    shreg_next   = shreg;
    bit_cnt_next = bit_cnt;
    terminal     = BIT_TERM;
    tx_done_tick = 1'b0;
`ifdef UART_PARITY_EN
    par_next     = par_bit;
`endif
    case (state)
      IDLE: begin
        if (host.tx_valid) begin
          shreg_next = host.tx_data;
`ifdef UART_PARITY_EN
          par_next   = (^host.tx_data) ^ (PAR_ODD != 0);
`endif
          state_next = START;
        end
      end
      START: begin
        if (tick_done) begin
          bit_cnt_next = '0;
          state_next   = DATA;
        end
      end
      DATA: begin
        if (tick_done) begin
          shreg_next = shreg >> 1;
          if (bit_cnt == LAST_BIT) begin
`ifdef UART_PARITY_EN
            state_next = PARITY;
`else
            state_next = STOP;
`endif
          end else begin
            bit_cnt_next = bit_cnt + 1'b1;
          end
        end
      end
`ifdef UART_PARITY_EN
      PARITY: begin
        if (tick_done) state_next = STOP;
      end
`endif
      STOP: begin
        terminal = STOP_TERM;
        if (tick_done) begin
          tx_done_tick = 1'b1;
          state_next   = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase

    case (state_next)
      START:   tx_next = 1'b0;
      DATA:    tx_next = shreg_next[0];
`ifdef UART_PARITY_EN
      PARITY:  tx_next = par_next;
`endif
      default: tx_next = 1'b1;
    endcase
  end
endmodule
